// File: rtl/data_mem_arbiter.sv
// Sequences load/store requesters onto the edge-triggered data memory: one
// registered strobe pulse per good access, fault checks done before any strobe.
module data_mem_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic [31:0]       ld_data,
    output logic              ld_fault,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_type,
    output logic              st_gnt,
    output logic              st_fault,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [2:0]        mem_wr_type,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    // Handshake: a requester holds req and operands stable until it samples
    // gnt high, and must change req on that same edge; gnt/fault pulse for
    // exactly one cycle and the FSM only looks at req again one edge later.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_ISSUE = 3'd1,
        LD_DONE  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic SERVED_LD = 1'b0;
    localparam logic SERVED_ST = 1'b1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t state;
    logic   last_served;

    logic [ADDR_W:0] ld_last;
    logic            ld_bad;
    logic [ADDR_W:0] st_span;
    logic [ADDR_W:0] st_last;
    logic            st_misalign;
    logic            st_bad_type;
    logic            st_bad;
    logic            pick_store;

    // One extra address bit keeps the last-byte sum from wrapping.
    assign ld_last = {1'b0, ld_addr} + (ADDR_W+1)'(3);
    assign ld_bad  = (ld_addr[1:0] != 2'b00) || (ld_last >= LIMIT);

    always_comb begin
        st_span     = '0;
        st_misalign = 1'b0;
        st_bad_type = 1'b0;
        case (st_type)
            3'b000: st_span = '0;
            3'b001: begin
                st_span     = (ADDR_W+1)'(1);
                st_misalign = st_addr[0];
            end
            3'b010: begin
                st_span     = (ADDR_W+1)'(3);
                st_misalign = (st_addr[1:0] != 2'b00);
            end
            default: st_bad_type = 1'b1;
        endcase
    end

    assign st_last = {1'b0, st_addr} + st_span;
    assign st_bad  = st_bad_type || st_misalign || (st_last >= LIMIT);

    // Round-robin: a tie goes to the store only if the load was served last.
    assign pick_store = st_req && (!ld_req || (last_served == SERVED_LD));

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= SERVED_LD;
            ld_gnt      <= 1'b0;
            ld_data     <= '0;
            ld_fault    <= 1'b0;
            st_gnt      <= 1'b0;
            st_fault    <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_type <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_store) begin
                        last_served <= SERVED_ST;
                        if (st_bad) begin
                            st_gnt   <= 1'b1;
                            st_fault <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            mem_wr_addr <= st_addr;
                            mem_wr_data <= st_data;
                            mem_wr_type <= st_type;
                            mem_wr_req  <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end else if (ld_req) begin
                        last_served <= SERVED_LD;
                        if (ld_bad) begin
                            ld_gnt   <= 1'b1;
                            ld_fault <= 1'b1;
                            ld_data  <= '0;
                            state    <= LD_DONE;
                        end else begin
                            mem_rd_addr <= ld_addr;
                            mem_rd_req  <= 1'b1;
                            state       <= LD_ISSUE;
                        end
                    end
                end
                LD_ISSUE: begin
                    // Memory captured the read on the strobe's rising edge.
                    mem_rd_req <= 1'b0;
                    ld_data    <= mem_rd_data;
                    ld_gnt     <= 1'b1;
                    ld_fault   <= 1'b0;
                    state      <= LD_DONE;
                end
                LD_DONE: begin
                    ld_gnt   <= 1'b0;
                    ld_fault <= 1'b0;
                    state    <= IDLE;
                end
                ST_ISSUE: begin
                    mem_wr_req <= 1'b0;
                    st_gnt     <= 1'b1;
                    st_fault   <= 1'b0;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    st_gnt   <= 1'b0;
                    st_fault <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with an edge-triggered byte memory model.
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_gnt;
    logic [31:0] ld_data;
    logic        ld_fault;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [2:0]  st_type = '0;
    logic        st_gnt;
    logic        st_fault;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [2:0]  mem_wr_type;
    logic        busy;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int wr_count = 0;

    logic [32:0] ld_exp_q[$];
    logic [0:0]  st_exp_q[$];
    logic [0:0]  order_q[$];

    logic [7:0] mem [0:1023] = '{default: 8'h00};

    data_mem_arbiter #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_data(ld_data), .ld_fault(ld_fault),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
        .st_gnt(st_gnt), .st_fault(st_fault),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_type(mem_wr_type), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Edge-triggered memory: acts on the rising edge of each strobe.
    always @(posedge mem_rd_req) begin
        logic [9:0] a;
        a = mem_rd_addr[9:0];
        mem_rd_data <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    end

    always @(posedge mem_wr_req) begin
        logic [9:0] a;
        a = mem_wr_addr[9:0];
        case (mem_wr_type)
            3'b000: mem[a] <= mem_wr_data[7:0];
            3'b001: begin
                mem[a]         <= mem_wr_data[7:0];
                mem[a + 10'd1] <= mem_wr_data[15:8];
            end
            3'b010: begin
                mem[a]         <= mem_wr_data[7:0];
                mem[a + 10'd1] <= mem_wr_data[15:8];
                mem[a + 10'd2] <= mem_wr_data[23:16];
                mem[a + 10'd3] <= mem_wr_data[31:24];
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever a grant appears; watches strobes.
    bit s_prev = 1'b0;
    bit s_seen = 1'b0;
    int s_high = 0;
    int s_low  = 0;

    always @(negedge clock) begin
        logic s;
        logic [32:0] e;
        check("strobe_exclusive", 64'(mem_rd_req & mem_wr_req), 64'd0);
        s = mem_rd_req | mem_wr_req;
        if (s) begin
            if (!s_prev) begin
                if (s_seen) check("strobe_gap_ge2", 64'(s_low >= 2), 64'd1);
                s_seen = 1'b1;
                s_low  = 0;
                s_high = 0;
                if (mem_rd_req) rd_count++;
                else wr_count++;
            end
            s_high++;
        end else begin
            if (s_prev) check("strobe_width", 64'(s_high), 64'd1);
            s_low++;
        end
        s_prev = s;

        if (ld_gnt) begin
            if (order_q.size() == 0) check("unexpected_ld_gnt", 64'd1, 64'd0);
            else check("grant_order", 64'd0, 64'(order_q.pop_front()));
            if (ld_exp_q.size() == 0) check("ld_exp_empty", 64'd1, 64'd0);
            else begin
                e = ld_exp_q.pop_front();
                check("ld_fault", 64'(ld_fault), 64'(e[32]));
                check("ld_data", 64'(ld_data), 64'(e[31:0]));
            end
        end
        if (st_gnt) begin
            if (order_q.size() == 0) check("unexpected_st_gnt", 64'd1, 64'd0);
            else check("grant_order", 64'd1, 64'(order_q.pop_front()));
            if (st_exp_q.size() == 0) check("st_exp_empty", 64'd1, 64'd0);
            else check("st_fault", 64'(st_fault), 64'(st_exp_q.pop_front()));
        end
    end

    // Driver tasks. exp_lat > 0: run alone, push own grant order, check latency.
    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_fault, input int exp_lat);
        int n;
        bit got;
        ld_exp_q.push_back({exp_fault, exp_data});
        if (exp_lat > 0) order_q.push_back(1'b0);
        @(negedge clock);
        ld_addr = addr;
        ld_req  = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clock);
            n++;
            if (ld_gnt) got = 1'b1;
        end
        if (!got) check("ld_gnt_timeout", 64'd1, 64'd0);
        else if (exp_lat > 0) check("ld_latency", 64'(n), 64'(exp_lat));
        @(posedge clock);
        #1 ld_req = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] typ,
                            input logic exp_fault, input int exp_lat);
        int n;
        bit got;
        st_exp_q.push_back(exp_fault);
        if (exp_lat > 0) order_q.push_back(1'b1);
        @(negedge clock);
        st_addr = addr;
        st_data = data;
        st_type = typ;
        st_req  = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clock);
            n++;
            if (st_gnt) got = 1'b1;
        end
        if (!got) check("st_gnt_timeout", 64'd1, 64'd0);
        else if (exp_lat > 0) check("st_latency", 64'(n), 64'(exp_lat));
        @(posedge clock);
        #1 st_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ld_gnt"}, 64'(ld_gnt), 64'd0);
        check({tag, "_ld_data"}, 64'(ld_data), 64'd0);
        check({tag, "_ld_fault"}, 64'(ld_fault), 64'd0);
        check({tag, "_st_gnt"}, 64'(st_gnt), 64'd0);
        check({tag, "_st_fault"}, 64'(st_fault), 64'd0);
        check({tag, "_mem_rd_req"}, 64'(mem_rd_req), 64'd0);
        check({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'd0);
        check({tag, "_mem_wr_req"}, 64'(mem_wr_req), 64'd0);
        check({tag, "_mem_wr_addr"}, 64'(mem_wr_addr), 64'd0);
        check({tag, "_mem_wr_data"}, 64'(mem_wr_data), 64'd0);
        check({tag, "_mem_wr_type"}, 64'(mem_wr_type), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2 check_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int wr_before;
        #1 reset_n = 1'b0;
        #2 check_zero("por");
        @(negedge clock);
        reset_n = 1'b1;

        // SW then LW at the same address
        do_store(32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 2);
        do_load(32'h10, 32'hDEADBEEF, 1'b0, 2);

        // Simultaneous requests right after reset: store wins the tie
        apply_reset();
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        fork
            do_store(32'h20, 32'h11223344, 3'b010, 1'b0, 0);
            do_load(32'h20, 32'h11223344, 1'b0, 0);
        join

        // Both requesters held for four accesses: ST, LD, ST, LD
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        fork
            begin
                do_store(32'h30, 32'hA5A50001, 3'b010, 1'b0, 0);
                do_store(32'h34, 32'h5A5A0002, 3'b010, 1'b0, 0);
            end
            begin
                do_load(32'h30, 32'hA5A50001, 1'b0, 0);
                do_load(32'h34, 32'h5A5A0002, 1'b0, 0);
            end
        join

        // Byte and halfword stores merge into one word
        do_store(32'h41, 32'h00000077, 3'b000, 1'b0, 2);
        do_store(32'h42, 32'h0000CAFE, 3'b001, 1'b0, 2);
        do_load(32'h40, 32'hCAFE7700, 1'b0, 2);
        do_store(32'h41, 32'h0000BEEF, 3'b001, 1'b1, 1);

        // Range and alignment boundaries
        wr_before = wr_count;
        do_store(32'h3FF, 32'h0000FFFF, 3'b001, 1'b1, 1);
        check("sh_3ff_no_strobe", 64'(wr_count), 64'(wr_before));
        do_store(32'h3FC, 32'h0BADF00D, 3'b010, 1'b0, 2);
        do_store(32'h3FF, 32'h00000012, 3'b000, 1'b0, 2);
        do_store(32'h3FD, 32'hFFFFFFFF, 3'b010, 1'b1, 1);
        do_load(32'h3FC, 32'h12ADF00D, 1'b0, 2);
        do_load(32'h3FE, 32'h00000000, 1'b1, 1);
        do_load(32'h400, 32'h00000000, 1'b1, 1);
        do_load(32'hFFFFFFFC, 32'h00000000, 1'b1, 1);

        // Illegal store type leaves memory untouched
        wr_before = wr_count;
        do_store(32'h0, 32'hFFFFFFFF, 3'b011, 1'b1, 1);
        check("bad_type_no_strobe", 64'(wr_count), 64'(wr_before));
        do_load(32'h0, 32'h00000000, 1'b0, 2);

        // Reset while the write strobe is high; the write itself lands
        @(negedge clock);
        st_addr = 32'h50;
        st_data = 32'h55AA55AA;
        st_type = 3'b010;
        st_req  = 1'b1;
        @(negedge clock);
        check("mid_reset_strobe_high", 64'(mem_wr_req), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_zero("mid_reset");
        st_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        do_load(32'h50, 32'h55AA55AA, 1'b0, 2);

        repeat (3) @(negedge clock);
        check("ld_q_drained", 64'(ld_exp_q.size()), 64'd0);
        check("st_q_drained", 64'(st_exp_q.size()), 64'd0);
        check("order_q_drained", 64'(order_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
